branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter branch history per entry.
- Sits in the IF stage. Predicts from PCF and drives next-PC selection.
- The prediction flags travel down the pipe as BranchPredictedE / BranchPredictedTakenE. The hazard unit uses them to detect mispredictions.
- Updated from the EX stage when a resolved conditional branch retires out of EX. Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and branch statistics
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 32 - INDEX_BITS - 2,
  parameter logic [1:0] CNT_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        BranchPredictedF,
  output logic        BranchPredictedTakenF,
  output logic [31:0] PredictedTargetF,
  input  logic        UpdateEnE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        BranchPredictedE,
  input  logic        BranchPredictedTakenE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [INDEX_BITS-1:0] fidx, eidx;
  logic [TAG_BITS-1:0]   ftag, etag;
  logic                  fhit, ehit;
  logic                  mispredict;
  logic                  alloc;
  logic                  write_target;
  logic [1:0]            cnt_next;

  // Byte-offset bits of both PCs carry no information for 4-byte aligned branches
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign fidx = PCF[INDEX_BITS+1:2];
  assign ftag = PCF[31:INDEX_BITS+2];
  assign eidx = PCE[INDEX_BITS+1:2];
  assign etag = PCE[31:INDEX_BITS+2];

  // Fetch lookup reads registered state only, so a same-cycle update is not seen until next cycle
  always_comb begin
    fhit                  = valid_q[fidx] && (tag_q[fidx] == ftag);
    BranchPredictedF      = fhit;
    BranchPredictedTakenF = fhit && cnt_q[fidx][1];
    PredictedTargetF      = fhit ? target_q[fidx] : PCF + 32'd4;
  end

  // Resolve the EX-stage update: hit check, counter step, allocation and mispredict detection
  always_comb begin
    ehit         = valid_q[eidx] && (tag_q[eidx] == etag);
    alloc        = !ehit && BranchE;
    write_target = UpdateEnE && BranchE;
    cnt_next     = cnt_q[eidx];
    if (alloc) begin
      cnt_next = CNT_INIT;
    end else if (BranchE) begin
      if (cnt_q[eidx] != 2'b11) cnt_next = cnt_q[eidx] + 2'd1;
    end else begin
      if (cnt_q[eidx] != 2'b00) cnt_next = cnt_q[eidx] - 2'd1;
    end
    // Kept identical to the hazard unit's flush condition
    mispredict = (BranchPredictedE && (BranchPredictedTakenE ^ BranchE)) ||
                 (!BranchPredictedE && BranchE);
  end

  // Valid bits and counters reset immediately; a reset mid-update drops the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b00;
    end else if (UpdateEnE && (ehit || alloc)) begin
      valid_q[eidx] <= 1'b1;
      cnt_q[eidx]   <= cnt_next;
    end
  end

  // Tag and target need no reset: an entry is only trusted once its valid bit is set
  always_ff @(posedge clk) begin
    if (write_target) begin
      tag_q[eidx]    <= etag;
      target_q[eidx] <= BranchTargetE;
    end
  end

  // Statistics counters wrap naturally and clear only on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else if (UpdateEnE) begin
      BranchCount <= BranchCount + 32'd1;
      if (mispredict) MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        BranchPredictedF;
  logic        BranchPredictedTakenF;
  logic [31:0] PredictedTargetF;
  logic        UpdateEnE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        BranchPredictedE;
  logic        BranchPredictedTakenE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  branch_predictor dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .PCF                  (PCF),
    .BranchPredictedF     (BranchPredictedF),
    .BranchPredictedTakenF(BranchPredictedTakenF),
    .PredictedTargetF     (PredictedTargetF),
    .UpdateEnE            (UpdateEnE),
    .PCE                  (PCE),
    .BranchE              (BranchE),
    .BranchTargetE        (BranchTargetE),
    .BranchPredictedE     (BranchPredictedE),
    .BranchPredictedTakenE(BranchPredictedTakenE),
    .BranchCount          (BranchCount),
    .MispredictCount      (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic hit, input logic taken, input logic [31:0] tgt);
    PCF = pc;
    #1;
    chk({tag, ".hit"},   {31'd0, BranchPredictedF},      {31'd0, hit});
    chk({tag, ".taken"}, {31'd0, BranchPredictedTakenF}, {31'd0, taken});
    chk({tag, ".tgt"},   PredictedTargetF,               tgt);
  endtask

  task automatic counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    chk({tag, ".bc"}, BranchCount, bc);
    chk({tag, ".mc"}, MispredictCount, mc);
  endtask

  task automatic update(input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                        input logic pe, input logic pte);
    @(negedge clk);
    PCE                   = pc;
    BranchE               = br;
    BranchTargetE         = tgt;
    BranchPredictedE      = pe;
    BranchPredictedTakenE = pte;
    UpdateEnE             = 1'b1;
    @(posedge clk);
    #1;
    UpdateEnE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    PCF = 32'h100;
    UpdateEnE = 1'b0;
    PCE = 32'h0;
    BranchE = 1'b0;
    BranchTargetE = 32'h0;
    BranchPredictedE = 1'b0;
    BranchPredictedTakenE = 1'b0;

    #2;
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    counts("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lookup("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);

    // First taken branch allocates weakly taken; unpredicted taken counts as mispredict
    update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    counts("alloc", 32'd1, 32'd1);

    // Not-taken walk: 10 -> 01 -> 00 -> 00 -> 00, flags carry the prior prediction
    update(32'h100, 1'b0, 32'hdead, 1'b1, 1'b1);
    lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h80);
    counts("nt1", 32'd2, 32'd2);
    update(32'h100, 1'b0, 32'hdead, 1'b1, 1'b0);
    lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b0, 32'hdead, 1'b1, 1'b0);
    lookup("nt3", 32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b0, 32'hdead, 1'b1, 1'b0);
    lookup("nt4", 32'h100, 1'b1, 1'b0, 32'h80);
    counts("nt4", 32'd5, 32'd2);

    // Two taken steps from a saturated 00: 01 (still not taken), then 10 (taken)
    update(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    lookup("sat1", 32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b1, 32'h80, 1'b1, 1'b0);
    lookup("sat2", 32'h100, 1'b1, 1'b1, 32'h80);
    counts("sat", 32'd7, 32'd4);

    // Same-cycle update and lookup on one index: read-before-write
    @(negedge clk);
    PCF                   = 32'h100;
    PCE                   = 32'h100;
    BranchE               = 1'b1;
    BranchTargetE         = 32'h90;
    BranchPredictedE      = 1'b1;
    BranchPredictedTakenE = 1'b1;
    UpdateEnE             = 1'b1;
    #1;
    chk("rbw.old", PredictedTargetF, 32'h80);
    @(posedge clk);
    #1;
    UpdateEnE = 1'b0;
    lookup("rbw.new", 32'h100, 1'b1, 1'b1, 32'h90);
    counts("rbw", 32'd8, 32'd4);

    // Alias at the same index evicts 0x100 and allocates with CNT_INIT
    update(32'h200, 1'b1, 32'h40, 1'b0, 1'b0);
    lookup("alias.old", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias.new", 32'h200, 1'b1, 1'b1, 32'h40);
    counts("alias", 32'd9, 32'd5);
    update(32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
    lookup("alias.init", 32'h200, 1'b1, 1'b0, 32'h40);
    counts("alias.init", 32'd10, 32'd6);

    // Update enable low: nothing changes even with taken inputs
    @(negedge clk);
    PCE = 32'h300; BranchE = 1'b1; BranchTargetE = 32'h44;
    BranchPredictedE = 1'b0; BranchPredictedTakenE = 1'b0;
    @(posedge clk);
    #1;
    lookup("noen", 32'h300, 1'b0, 1'b0, 32'h304);
    counts("noen", 32'd10, 32'd6);

    // Miss and not taken: counted, no allocation, not a mispredict
    update(32'h300, 1'b0, 32'h44, 1'b0, 1'b0);
    lookup("miss_nt", 32'h300, 1'b0, 1'b0, 32'h304);
    counts("miss_nt", 32'd11, 32'd6);

    // Asynchronous reset between edges while an update is pending
    @(negedge clk);
    PCF = 32'h200;
    PCE = 32'h400; BranchE = 1'b1; BranchTargetE = 32'h44;
    BranchPredictedE = 1'b0; BranchPredictedTakenE = 1'b0;
    UpdateEnE = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.hit", {31'd0, BranchPredictedF}, 32'd0);
    chk("arst.taken", {31'd0, BranchPredictedTakenF}, 32'd0);
    chk("arst.tgt", PredictedTargetF, 32'h204);
    counts("arst", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    UpdateEnE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    lookup("arst.400", 32'h400, 1'b0, 1'b0, 32'h404);
    lookup("arst.200", 32'h200, 1'b0, 1'b0, 32'h204);
    counts("arst.rel", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
